// File: rtl/alu_op_sequencer.sv
// Sequences one serial ALU command: holds its control fields, strobes beats
// (stalling on the external operand stream), repeats passes, and checks op_done.
module alu_op_sequencer #(
  parameter int LOG2_NR  = 4,
  parameter int REG_BITS = 8,
  parameter int NSHIFT   = 2,
  parameter int OP_BITS  = 3,
  parameter int REP_BITS = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [OP_BITS-1:0]  cmd_op,
  input  logic [LOG2_NR-1:0]  cmd_reg1,
  input  logic [LOG2_NR-1:0]  cmd_reg2,
  input  logic                cmd_pair,
  input  logic                cmd_ext2,
  input  logic                cmd_update_reg1,
  input  logic [1:0]          cmd_flags,
  input  logic [REP_BITS-1:0] cmd_repeat,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                alu_op_done,
  output logic [OP_BITS-1:0]  alu_operation,
  output logic [LOG2_NR-1:0]  alu_reg1,
  output logic [LOG2_NR-1:0]  alu_reg2,
  output logic                alu_pair_op,
  output logic                alu_external_arg2,
  output logic                alu_update_reg1,
  output logic                alu_update_carry_flags,
  output logic                alu_update_other_flags,
  output logic                alu_regfile_en,
  output logic                alu_advance,
  output logic                busy,
  output logic                done,
  output logic                err
);
  localparam int BEATS_W = $clog2(2*REG_BITS/NSHIFT);
  localparam logic [BEATS_W-1:0] LAST_PAIR = BEATS_W'(2*REG_BITS/NSHIFT - 1);
  localparam logic [BEATS_W-1:0] LAST_SNGL = BEATS_W'(REG_BITS/NSHIFT - 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t              state;
  logic [BEATS_W-1:0]  beat;
  logic [REP_BITS-1:0] pass, rep;
  logic [1:0]          flags;
  logic                adv, last_beat, final_pass, retire;

  assign busy           = (state == RUN);
  assign adv            = busy && !(alu_external_arg2 && !in_valid);
  assign alu_advance    = adv;
  assign alu_regfile_en = adv;
  assign in_ready       = adv && alu_external_arg2;
  assign last_beat      = adv && (beat == (alu_pair_op ? LAST_PAIR : LAST_SNGL));
  assign final_pass     = (pass == rep);
  assign retire         = last_beat && final_pass;
  // Accepting on the retiring beat lets a queued command start with no bubble.
  assign cmd_ready      = !busy || retire;

  assign alu_update_carry_flags = flags[1] && final_pass;
  assign alu_update_other_flags = flags[0] && final_pass;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      beat              <= '0;
      pass              <= '0;
      rep               <= '0;
      flags             <= '0;
      alu_operation     <= '0;
      alu_reg1          <= '0;
      alu_reg2          <= '0;
      alu_pair_op       <= 1'b0;
      alu_external_arg2 <= 1'b0;
      alu_update_reg1   <= 1'b0;
      done              <= 1'b0;
      err               <= 1'b0;
    end else begin
      done <= retire;
      // op_done only means something on cycles that actually advance the ALU.
      if (adv && (alu_op_done != last_beat)) err <= 1'b1;
      if (cmd_valid && cmd_ready) begin
        state             <= RUN;
        beat              <= '0;
        pass              <= '0;
        rep               <= cmd_repeat;
        flags             <= cmd_flags;
        alu_operation     <= cmd_op;
        alu_reg1          <= cmd_reg1;
        alu_reg2          <= cmd_reg2;
        alu_pair_op       <= cmd_pair;
        alu_external_arg2 <= cmd_ext2;
        alu_update_reg1   <= cmd_update_reg1;
      end else if (retire) begin
        state <= IDLE;
      end else if (last_beat) begin
        pass <= pass + 1'b1;
        beat <= '0;
      end else if (adv) begin
        beat <= beat + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench: stimulus pushes per-cycle expectations and retire cycles;
// a negedge monitor pops and compares them against the sequencer outputs.
module tb_alu_op_sequencer;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_ready;
  logic [2:0] cmd_op;
  logic [3:0] cmd_reg1, cmd_reg2;
  logic       cmd_pair, cmd_ext2, cmd_update_reg1;
  logic [1:0] cmd_flags;
  logic [2:0] cmd_repeat;
  logic       in_valid, in_ready, alu_op_done;
  logic [2:0] alu_operation;
  logic [3:0] alu_reg1, alu_reg2;
  logic       alu_pair_op, alu_external_arg2, alu_update_reg1;
  logic       alu_update_carry_flags, alu_update_other_flags;
  logic       alu_regfile_en, alu_advance, busy, done, err;

  alu_op_sequencer dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_reg1(cmd_reg1), .cmd_reg2(cmd_reg2), .cmd_pair(cmd_pair),
    .cmd_ext2(cmd_ext2), .cmd_update_reg1(cmd_update_reg1), .cmd_flags(cmd_flags),
    .cmd_repeat(cmd_repeat), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op_done(alu_op_done), .alu_operation(alu_operation), .alu_reg1(alu_reg1),
    .alu_reg2(alu_reg2), .alu_pair_op(alu_pair_op), .alu_external_arg2(alu_external_arg2),
    .alu_update_reg1(alu_update_reg1), .alu_update_carry_flags(alu_update_carry_flags),
    .alu_update_other_flags(alu_update_other_flags), .alu_regfile_en(alu_regfile_en),
    .alu_advance(alu_advance), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] op;
    logic [3:0] r1, r2;
    logic       pair, ext2, upd;
    logic [1:0] flags;
    logic [2:0] rep;
  } cmd_t;

  typedef struct packed {
    logic       adv, iready, cready;
    logic [2:0] op;
    logic [3:0] r1, r2;
    logic       pair, ext2, upd, cf, of;
  } exp_t;

  localparam int BIG = 1 << 30;

  exp_t beat_q[$];
  int   done_q[$];
  int   cyc = 0;
  int   err_from = BIG;
  int   n_cmp = 0, n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %h want %h", name, cyc, act, want);
    end
  endtask

  // Monitor: samples at negedge, away from the active edge.
  always @(negedge clk) begin
    exp_t a, e;
    a = {alu_advance, in_ready, cmd_ready, alu_operation, alu_reg1, alu_reg2, alu_pair_op,
         alu_external_arg2, alu_update_reg1, alu_update_carry_flags, alu_update_other_flags};
    if (!rst_n) begin
      chk("reset", {busy, done, err, alu_advance, alu_regfile_en, in_ready, alu_operation,
                    alu_reg1, alu_reg2, alu_pair_op, alu_external_arg2, alu_update_reg1,
                    alu_update_carry_flags, alu_update_other_flags}, '0);
    end else begin
      chk("strobe_eq", alu_regfile_en, alu_advance);
      chk("err", err, cyc >= err_from);
      if (busy) begin
        if (beat_q.size() == 0) chk("beat_unexp", busy, 0);
        else begin
          e = beat_q.pop_front();
          chk("beat", a, e);
        end
      end else begin
        chk("idle", {cmd_ready, alu_advance, in_ready}, 3'b100);
      end
      if (done) begin
        if (done_q.size() == 0) chk("done_unexp", done, 0);
        else chk("done_cyc", cyc, done_q.pop_front());
      end else if (done_q.size() != 0 && cyc >= done_q[0]) begin
        chk("done_miss", done, 1);
        void'(done_q.pop_front());
      end
    end
  end

  task automatic drive(input cmd_t c);
    cmd_op = c.op; cmd_reg1 = c.r1; cmd_reg2 = c.r2; cmd_pair = c.pair;
    cmd_ext2 = c.ext2; cmd_update_reg1 = c.upd; cmd_flags = c.flags; cmd_repeat = c.rep;
  endtask

  function automatic exp_t mk(input cmd_t c, input bit fin);
    exp_t e;
    e = '0;
    e.op = c.op; e.r1 = c.r1; e.r2 = c.r2; e.pair = c.pair; e.ext2 = c.ext2; e.upd = c.upd;
    e.cf = c.flags[1] && fin;
    e.of = c.flags[0] && fin;
    return e;
  endfunction

  // stl[b]: operand stream empty for one cycle before beat b; bad: extra op_done on
  // beat b; abort: reset asserted during beat b; pre: already accepted; chain: offer nx
  // on the final beat.
  task automatic run(input cmd_t c, input logic [63:0] stl, input int bad, input int abort,
                     input bit pre, input bit chain, input cmd_t nx);
    int nb, tot, ns;
    exp_t e;
    nb = c.pair ? 8 : 4;
    tot = nb * (int'(c.rep) + 1);
    if (!pre) begin
      drive(c); cmd_valid = 1'b1;
      @(posedge clk); #2;
    end
    cmd_valid = 1'b0;
    ns = 0;
    for (int b = 0; b < tot; b++) begin
      e = mk(c, (b / nb) == int'(c.rep));
      if (c.ext2 && stl[b]) begin
        e.adv = 1'b0; e.iready = 1'b0; e.cready = 1'b0;
        beat_q.push_back(e); ns++;
      end
      e.adv = 1'b1; e.iready = c.ext2; e.cready = (b == tot - 1);
      beat_q.push_back(e);
    end
    done_q.push_back(cyc + tot + ns);
    for (int b = 0; b < tot; b++) begin
      if (c.ext2 && stl[b]) begin
        in_valid = 1'b0; alu_op_done = 1'b1;
        @(posedge clk); #2;
      end
      in_valid = c.ext2;
      alu_op_done = ((b % nb) == nb - 1) || (b == bad);
      if (b == bad && err_from > cyc + 1) err_from = cyc + 1;
      if (b == abort) begin
        rst_n = 1'b0;
        beat_q.delete(); done_q.delete(); err_from = BIG;
        @(posedge clk); #2;
        rst_n = 1'b1; in_valid = 1'b0; alu_op_done = 1'b0;
        return;
      end
      if (chain && b == tot - 1) begin drive(nx); cmd_valid = 1'b1; end
      @(posedge clk); #2;
    end
    in_valid = 1'b0; alu_op_done = 1'b0;
    if (!chain) cmd_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit hit");
    $fatal(1, "watchdog");
  end

  initial begin
    cmd_t c1, c2, c3, c4a, c4b, c5, c6, c7, c8;
    //        op    r1     r2     pr  ex  up  flg    rep
    c1  = '{3'd0, 4'd3,  4'd5,  0,  0,  1,  2'b11, 3'd0};
    c2  = '{3'd1, 4'd2,  4'd7,  1,  1,  1,  2'b11, 3'd0};
    c3  = '{3'd2, 4'd4,  4'd1,  0,  0,  0,  2'b11, 3'd2};
    c4a = '{3'd3, 4'd1,  4'd2,  0,  0,  1,  2'b10, 3'd0};
    c4b = '{3'd4, 4'd9,  4'd10, 0,  0,  0,  2'b01, 3'd0};
    c5  = '{3'd5, 4'd6,  4'd6,  0,  0,  1,  2'b11, 3'd0};
    c6  = '{3'd6, 4'd15, 4'd0,  1,  0,  1,  2'b11, 3'd0};
    c7  = '{3'd7, 4'd8,  4'd9,  1,  1,  1,  2'b11, 3'd0};
    c8  = '{3'd0, 4'd12, 4'd13, 0,  1,  1,  2'b11, 3'd7};
    rst_n = 1'b0; cmd_valid = 1'b0; in_valid = 1'b0; alu_op_done = 1'b0;
    drive('0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #2;
    run(c1,  64'h0,          -1, -1, 0, 0, c1);   // plain 8-bit
    run(c2,  64'h24,         -1, -1, 0, 0, c2);   // 16-bit, stalls before beats 2 and 5
    run(c3,  64'h0,          -1, -1, 0, 0, c3);   // three passes, flags only on last
    run(c4a, 64'h0,          -1, -1, 0, 1, c4b);  // back-to-back
    run(c4b, 64'h0,          -1, -1, 1, 0, c4b);
    run(c5,  64'h0,           2, -1, 0, 0, c5);   // early op_done -> sticky err
    run(c6,  64'h0,          -1, -1, 0, 0, c6);
    run(c7,  64'h0,          -1,  5, 0, 0, c7);   // reset mid-command
    run(c8,  64'h8000_0001,  -1, -1, 0, 0, c8);   // max passes, stall on final beat
    repeat (3) @(posedge clk);
    #2;
    chk("drained", beat_q.size() + done_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
